// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the stepper command stage.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int DEF_CNT_W         = 16;
    localparam int DEF_MIN_PERIOD    = 2;
    localparam int DEF_SETTLE_CYCLES = 8;

endpackage

// File: rtl/step_timer.sv
// Loadable period counter: ticks when the count reaches period-1, then wraps to 0.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic         tick
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;
    logic [W-1:0] period_q;

    assign tick = en && (count == (period_q - ONE));

    // load wins over counting so a new period always starts from a clean 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            period_q <= '0;
        end else if (load) begin
            count    <= '0;
            period_q <= period;
        end else if (en) begin
            count <= tick ? '0 : count + ONE;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Move command stage: accepts step/dir/period commands, paces step pulses,
// tracks absolute position and signals completion after a settle hold.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int MIN_PERIOD    = DEF_MIN_PERIOD,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_period,
    input  logic             abort,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pos,
    output state_t           fsm_state
);

    // Handshake: a command transfers in any cycle where cmd_valid and cmd_ready
    // are both high; cmd_ready is high exactly while the FSM is IDLE.

    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] SETTLE_P = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam bit               NO_SETTLE = (SETTLE_CYCLES == 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] steps_left;
    logic [CNT_W-1:0] run_period;
    logic [CNT_W-1:0] load_period;
    logic             timer_load;
    logic             timer_en;
    logic             tick;
    logic             step_c;
    logic             done_d;
    logic             enter_settle;
    logic             accept;

    assign run_period = (cmd_period < MIN_P) ? MIN_P : cmd_period;
    assign accept     = (state_q == IDLE) && cmd_valid;
    assign timer_en   = (state_q != IDLE);

    step_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .period (load_period),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        timer_load   = 1'b0;
        load_period  = run_period;
        step_c       = 1'b0;
        done_d       = 1'b0;
        enter_settle = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    timer_load = 1'b1;
                    if (cmd_steps == '0) enter_settle = 1'b1;
                    else                 state_d = RUN;
                end
            end
            RUN: begin
                // abort suppresses a step that would otherwise fire this cycle
                if (abort) begin
                    enter_settle = 1'b1;
                end else if (tick) begin
                    step_c = 1'b1;
                    if (steps_left == ONE) enter_settle = 1'b1;
                end
            end
            SETTLE: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_settle) begin
            if (NO_SETTLE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d     = SETTLE;
                timer_load  = 1'b1;
                load_period = SETTLE_P;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            steps_left <= '0;
            dir        <= DIR_FWD;
            pos        <= '0;
            done       <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            if (accept) begin
                steps_left <= cmd_steps;
                dir        <= cmd_dir;
            end else if (step_c) begin
                steps_left <= steps_left - ONE;
                pos        <= (dir == DIR_REV) ? pos - ONE : pos + ONE;
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign step      = step_c;
    assign fsm_state = state_q;

endmodule
